fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one 8-bit synchronous FIFO write port among N_REQ requesters. Each requester presents valid/data/last; the arbiter grants one requester at a time and holds the grant until the requester's packet ends or a burst limit is reached. It drives the FIFO's wr_en and data_in and honours full. It sits directly in front of fifo_sync, in the same clock domain.

## Interface
- N_REQ, 4: number of requesters; values 2..8.
- DATA_W, 8: data width; must equal the FIFO data width.
- MAX_BURST, 8: maximum beats per grant before forced re-arbitration; values 1..16.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester data valid.
- req_data  in  N_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  final beat of the packet; sampled only with valid.
- req_ready  out  N_REQ  one-hot or zero; beat i accepted when req_valid[i] && req_ready[i].
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_data_in  out  DATA_W  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- grant_id  out  3  index of current/last granted requester.
- busy  out  1  high while a grant is held.

## Operation
- Two-state FSM: IDLE, GRANT.
- IDLE: if any req_valid is set, select the first set bit searching upward from (last_grant+1) mod N_REQ with wrap. Register it into grant_id, clear beat_cnt, and go to GRANT. Otherwise stay in IDLE.
- GRANT: req_ready[grant_id] = !fifo_full. All other ready bits are 0.
- fifo_wr_en = GRANT && req_valid[grant_id] && !fifo_full. It is combinational, so each beat enters the FIFO in the same cycle it is accepted.
- fifo_data_in = req_data slice of grant_id, always driven. Its value is don't-care when wr_en is low.
- fifo_wr_en is never high while fifo_full is high. The FIFO's occupancy count increments on wr_en without gating, so this rule is mandatory.
- On each accepted beat, beat_cnt increments. beat_cnt is 4 bits, saturating behaviour is not needed, and it is cleared on grant.
- Grant release: on an accepted beat with req_last=1 or beat_cnt==MAX_BURST-1, the next state is IDLE and last_grant is set to grant_id.
- A requester that deasserts valid mid-packet keeps the grant. The arbiter waits with no timeout.
- A held grant is never pre-empted by other requesters, regardless of index.
- busy = (state == GRANT).

## Timing
- Reset (reset_n low, asynchronous) sets:
  - state = IDLE, grant_id = 0, last_grant = N_REQ-1 (requester 0 has first priority), beat_cnt = 0.
  - All outputs low: req_ready = 0, fifo_wr_en = 0, busy = 0.
- Reset deassertion takes effect on the first rising clk after reset_n is high.
- Arbitration latency: valid seen in IDLE at edge k means grant registered at edge k, and the first beat can be accepted in cycle k+1. That is one bubble cycle per grant.
- Throughput in GRANT: one beat per cycle while valid && !fifo_full.
- Back-to-back packets always pass through IDLE, so there is one idle cycle between grants.
- fifo_full rising mid-packet: ready drops in the same cycle, the beat stalls, and it resumes when full falls.
- Reset mid-packet: the grant is abandoned, and the partially written packet remains in the FIFO. The FIFO's own reset handles the flush.
- Simultaneous valid from all requesters: grant order is strictly rotating, e.g. 0,1,2,3,0 for N_REQ=4.

## Test plan
- Reset, then requester 2 only, with a 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3) → grant_id=2 one cycle after valid; fifo_wr_en high for 3 consecutive cycles with those data; busy drops after the third beat.
- All 4 requesters valid, each sending 1-beat packets repeatedly → grants in order 0,1,2,3,0; each write separated by exactly one idle cycle.
- Requester 1 sends a 20-beat packet with MAX_BURST=8 while requester 3 is also valid → 8 beats from 1, then 8 from 3 (if its packet is long), then 1 resumes; no beat is lost or duplicated.
- fifo_full forced high for 5 cycles in the middle of a 6-beat packet → fifo_wr_en and req_ready are 0 throughout the stall; the remaining beats follow in order afterwards; the FIFO count never exceeds 8.
- Granted requester drops valid for 4 cycles mid-packet while others are valid → grant is held, no writes occur, and no other ready asserts.
- reset_n pulsed low during a beat → all outputs go low immediately (no clock needed); after release, the next arbitration starts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side arbiter bus bundle.
//   master: the arbiter (consumes requester valid/data/last and fifo_full,
//           drives ready, the FIFO write port, grant_id and busy)
//   slave : the environment (requesters plus FIFO status)
interface fifo_wr_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_data_in;
    logic                    fifo_full;
    logic [2:0]              grant_id;
    logic                    busy;

    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among N_REQ
// requesters. A grant is held until the packet's last beat or MAX_BURST
// beats, then the arbiter returns to IDLE for one cycle and rotates.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - fifo_wr_arbiter_if.master (requester handshakes, FIFO write
//             port, fifo_full, grant_id, busy)
// req_ready / fifo_wr_en / fifo_data_in are combinational so a beat is
// written into the FIFO in the same cycle it is accepted.
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    fifo_wr_arbiter_if.master  bus
);
    localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   beat_q, beat_d;

    logic [N_REQ-1:0]   ready_c;
    logic               accept_c;
    logic               sel_found_c;
    logic [SEL_W-1:0]   sel_idx_c;
    logic [SEL_W-1:0]   cand_c;
    logic [DATA_W-1:0]  data_a [N_REQ];

    // Unpack the flat requester data bus for indexed muxing.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_a[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // Rotating priority search starting just after the last granted index.
    always_comb begin
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        cand_c      = last_grant_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_c = (cand_c == LAST_IDX) ? '0 : cand_c + SEL_W'(1);
            if (!sel_found_c && bus.req_valid[cand_c]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = cand_c;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_IDX;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        ready_c      = '0;
        accept_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found_c) begin
                    grant_d = sel_idx_c;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Ready is withheld while full so the FIFO is never overrun.
                ready_c[grant_q] = !bus.fifo_full;
                accept_c         = bus.req_valid[grant_q] && !bus.fifo_full;
                if (accept_c) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (bus.req_last[grant_q] || (beat_q == LAST_BEAT)) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready    = ready_c;
    assign bus.fifo_wr_en   = accept_c;
    assign bus.fifo_data_in = data_a[grant_q];
    assign bus.grant_id     = 3'(grant_q);
    assign bus.busy         = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester sources are queues of
// {last,data} beats; expected FIFO writes {id,data} are queued when the
// stimulus is set up and popped on every fifo_wr_en.
module tb_fifo_wr_arbiter;
    localparam int unsigned N_REQ     = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 8;

    logic clk;
    logic reset_n;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    fifo_wr_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0]       src_q [N_REQ][$];
    logic [10:0]      sb_q [$];
    logic [N_REQ-1:0] mask_r;
    int               n_checks;
    int               n_errors;
    int               cycle;
    int               wr_count;
    int               last_wr_cycle;
    bit               gap_chk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic add_pkt(input int r, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            src_q[r].push_back({(i == n - 1), 8'(base + 8'(i))});
    endtask

    task automatic exp_beats(input int r, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            sb_q.push_back({3'(r), 8'(base + 8'(i))});
    endtask

    task automatic drive();
        logic [N_REQ-1:0]        v;
        logic [N_REQ-1:0]        l;
        logic [N_REQ*DATA_W-1:0] d;
        logic [8:0]              beat;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (mask_r[i] && src_q[i].size() > 0) begin
                beat = src_q[i][0];
                v[i] = 1'b1;
                l[i] = beat[8];
                d[i*DATA_W +: DATA_W] = beat[7:0];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    // One clock: drive, monitor at negedge, retire accepted beats after posedge.
    task automatic step();
        logic [N_REQ-1:0] acc;
        logic [10:0]      exp;
        drive();
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        check_eq("accept_vs_wr", 32'($countones(acc)), 32'(bus.fifo_wr_en));
        if (bus.fifo_full) begin
            check_eq("stall_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            check_eq("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        if (bus.fifo_wr_en) begin
            wr_count++;
            check_eq("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                check_eq("wr_data", 32'(bus.fifo_data_in), 32'(exp[7:0]));
                check_eq("wr_id", 32'(bus.grant_id), 32'(exp[10:8]));
            end
            if (gap_chk && last_wr_cycle >= 0)
                check_eq("wr_gap", 32'(cycle - last_wr_cycle), 32'd2);
            last_wr_cycle = cycle;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N_REQ); i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        cycle++;
    endtask

    task automatic run_until_empty(input int bound);
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < bound) begin
            step();
            n++;
        end
        check_eq("drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        step();
    endtask

    // Asserts reset, checks the outputs fall with no clock, flushes sources.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_grant", 32'(bus.grant_id), 32'd0);
        for (int i = 0; i < int'(N_REQ); i++) src_q[i].delete();
        sb_q.delete();
        step();
        step();
        reset_n = 1'b1;
    endtask

    int base_wr;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cycle         = 0;
        wr_count      = 0;
        last_wr_cycle = -1;
        gap_chk       = 1'b0;
        mask_r        = '1;
        reset_n       = 1'b1;
        bus.fifo_full = 1'b0;
        drive();
        #1;
        do_reset();

        // Single requester, 3-beat packet.
        add_pkt(2, 3, 8'hA1);
        exp_beats(2, 3, 8'hA1);
        step();
        check_eq("t1_grant", 32'(bus.grant_id), 32'd2);
        check_eq("t1_busy", 32'(bus.busy), 32'd1);
        base_wr = wr_count;
        repeat (3) step();
        check_eq("t1_writes", 32'(wr_count - base_wr), 32'd3);
        check_eq("t1_busy_end", 32'(bus.busy), 32'd0);
        check_eq("t1_drain", 32'(sb_q.size()), 32'd0);

        // All requesters, 1-beat packets, strict rotation with one idle gap.
        do_reset();
        for (int r = 0; r < int'(N_REQ); r++) begin
            add_pkt(r, 1, 8'(8'h30 + 8'(r)));
            add_pkt(r, 1, 8'(8'h40 + 8'(r)));
        end
        for (int r = 0; r < int'(N_REQ); r++) exp_beats(r, 1, 8'(8'h30 + 8'(r)));
        for (int r = 0; r < int'(N_REQ); r++) exp_beats(r, 1, 8'(8'h40 + 8'(r)));
        gap_chk       = 1'b1;
        last_wr_cycle = -1;
        run_until_empty(40);
        gap_chk = 1'b0;

        // Burst limit: 20-beat packet from 1 competing with 10-beat from 3.
        add_pkt(1, 20, 8'h10);
        add_pkt(3, 10, 8'h80);
        exp_beats(1, 8, 8'h10);
        exp_beats(3, 8, 8'h80);
        exp_beats(1, 8, 8'h18);
        exp_beats(3, 2, 8'h88);
        exp_beats(1, 4, 8'h20);
        run_until_empty(80);

        // FIFO full for 5 cycles in the middle of a 6-beat packet.
        add_pkt(0, 6, 8'hC0);
        exp_beats(0, 6, 8'hC0);
        repeat (3) step();
        check_eq("t4_pre_writes", 32'(sb_q.size()), 32'd4);
        bus.fifo_full = 1'b1;
        base_wr = wr_count;
        repeat (5) begin
            step();
            check_eq("t4_busy", 32'(bus.busy), 32'd1);
        end
        check_eq("t4_stall_writes", 32'(wr_count - base_wr), 32'd0);
        bus.fifo_full = 1'b0;
        run_until_empty(20);

        // Granted requester drops valid mid-packet; grant must hold.
        add_pkt(2, 5, 8'hE0);
        add_pkt(3, 1, 8'hF3);
        add_pkt(0, 1, 8'hF0);
        exp_beats(2, 5, 8'hE0);
        exp_beats(3, 1, 8'hF3);
        exp_beats(0, 1, 8'hF0);
        step();
        check_eq("t5_grant", 32'(bus.grant_id), 32'd2);
        repeat (2) step();
        mask_r[2] = 1'b0;
        base_wr = wr_count;
        repeat (4) begin
            step();
            check_eq("t5_hold_grant", 32'(bus.grant_id), 32'd2);
            check_eq("t5_hold_ready", 32'(bus.req_ready), 32'b0100);
            check_eq("t5_hold_busy", 32'(bus.busy), 32'd1);
        end
        check_eq("t5_hold_writes", 32'(wr_count - base_wr), 32'd0);
        mask_r[2] = 1'b1;
        run_until_empty(30);

        // Reset during an accepted beat, then arbitration restarts at 0.
        add_pkt(1, 4, 8'h50);
        exp_beats(1, 2, 8'h50);
        step();
        check_eq("t6_grant", 32'(bus.grant_id), 32'd1);
        repeat (2) step();
        drive();
        #1;
        check_eq("t6_pre_rst_wr", 32'(bus.fifo_wr_en), 32'd1);
        check_eq("t6_pre_rst_sb", 32'(sb_q.size()), 32'd0);
        do_reset();
        add_pkt(0, 1, 8'h60);
        add_pkt(1, 1, 8'h61);
        exp_beats(0, 1, 8'h60);
        exp_beats(1, 1, 8'h61);
        step();
        check_eq("t6_restart_grant", 32'(bus.grant_id), 32'd0);
        run_until_empty(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
